// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Round-robin arbiter that serialises NUM_CH multi-byte requests onto an
//   8-bit RAM/IO bus. The RAM has one cycle of read latency. Each request
//   moves 1..4 bytes, little-endian. While rdy_in is low the bus is lent out:
//   nothing is issued, and the transfer rewinds to the lowest byte that has
//   not yet completed.
//
// Ports
//   clk_in, rstn_in      clock, asynchronous active-low reset
//   rdy_in               bus available (low = frozen)
//   req_in/wr_in         per-channel request / write flag
//   len_in               per-channel byte count minus 1 (2 bits each)
//   addr_in/wdata_in     per-channel start address / write data
//   done_out             one-cycle completion pulse to the served channel
//   rdata_out            read word (meaningful while done_out is high)
//   mem_din/mem_dout     bus read byte (1-cycle latency) / write byte
//   mem_a/mem_wr         bus address / write strobe
//   io_access_out        current issue cycle targets the IO region

// Per-channel slice: completion pulse and arbitration eligibility.
module mem_bus_arbiter_lane (
  input  logic req,
  input  logic sel,
  input  logic done_fire,
  output logic elig,
  output logic done
);
  assign done = sel & done_fire;
  // A channel still sees its own done pulse this cycle, and its req is
  // still high. Keep it out of arbitration so it is not served twice.
  assign elig = req & ~done;
endmodule

module mem_bus_arbiter #(
  parameter int NUM_CH         = 3,
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 17
) (
  input  logic                       clk_in,
  input  logic                       rstn_in,
  input  logic                       rdy_in,
  input  logic [NUM_CH-1:0]          req_in,
  input  logic [NUM_CH-1:0]          wr_in,
  input  logic [2*NUM_CH-1:0]        len_in,
  input  logic [ADDR_WIDTH*NUM_CH-1:0] addr_in,
  input  logic [32*NUM_CH-1:0]       wdata_in,
  output logic [NUM_CH-1:0]          done_out,
  output logic [31:0]                rdata_out,
  input  logic [7:0]                 mem_din,
  output logic [7:0]                 mem_dout,
  output logic [ADDR_WIDTH-1:0]      mem_a,
  output logic                       mem_wr,
  output logic                       io_access_out
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  typedef struct packed {
    logic                  wr;
    logic [1:0]            len;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
  } req_t;

  state_t                state;
  req_t                  chan_req [NUM_CH];
  req_t                  cur;
  logic [CW-1:0]         cur_ch, prio, gnt_ch;
  logic                  gnt_vld, done_fire;
  logic [NUM_CH-1:0]     elig;

  // vld_pipe[0]: a byte is on the bus this cycle (issue stage)
  // vld_pipe[1]: a read byte issued last cycle is captured this cycle
  logic [1:0]            vld_pipe;
  logic [1:0]            idx0, idx1;   // byte index at each stage
  logic [1:0]            cnt;          // lowest byte not yet completed
  logic [31:0]           rdata_q;
  logic [ADDR_WIDTH-1:0] mem_a_q;
  logic [7:0]            mem_dout_q;

  assign done_fire = (state == DONE) & rdy_in;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign chan_req[i] = '{wr:    wr_in[i],
                           len:   len_in[2*i +: 2],
                           addr:  addr_in[ADDR_WIDTH*i +: ADDR_WIDTH],
                           wdata: wdata_in[32*i +: 32]};
    mem_bus_arbiter_lane u_lane (
      .req       (req_in[i]),
      .sel       (cur_ch == CW'(i)),
      .done_fire (done_fire),
      .elig      (elig[i]),
      .done      (done_out[i])
    );
  end

  // Round-robin pick starting at prio. The loop runs in reverse, so the
  // candidate closest to prio is written last and wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(prio) + k) % NUM_CH;
      if (elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_ch  = CW'(idx);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state      <= IDLE;
      prio       <= '0;
      cur_ch     <= '0;
      cur        <= '0;
      vld_pipe   <= '0;
      idx0       <= '0;
      idx1       <= '0;
      cnt        <= '0;
      rdata_q    <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
    end else if (!rdy_in) begin
      // Bus lent out. A byte on the bus this cycle was not really issued,
      // and a read byte due for capture is lost. Rewind to the first
      // incomplete byte so it is re-issued in the first cycle rdy returns.
      if (state == XFER) begin
        vld_pipe   <= 2'b01;
        idx0       <= cnt;
        mem_a_q    <= cur.addr + ADDR_WIDTH'(cnt);
        mem_dout_q <= cur.wdata[{cnt, 3'b000} +: 8];
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (gnt_vld) begin
            cur        <= chan_req[gnt_ch];
            cur_ch     <= gnt_ch;
            prio       <= (gnt_ch == CW'(NUM_CH - 1)) ? '0 : CW'(gnt_ch + 1'b1);
            state      <= XFER;
            vld_pipe   <= 2'b01;
            idx0       <= '0;
            idx1       <= '0;
            cnt        <= '0;
            rdata_q    <= '0;
            mem_a_q    <= chan_req[gnt_ch].addr;
            mem_dout_q <= chan_req[gnt_ch].wdata[7:0];
          end
        end
        XFER: begin
          if (cur.wr) begin
            // A write byte completes when it is issued.
            if (vld_pipe[0]) begin
              cnt <= idx0 + 2'd1;
              if (idx0 == cur.len) begin
                vld_pipe[0] <= 1'b0;
                state       <= DONE;
              end else begin
                idx0       <= idx0 + 2'd1;
                mem_a_q    <= mem_a_q + ADDR_WIDTH'(1);
                mem_dout_q <= cur.wdata[{idx0 + 2'd1, 3'b000} +: 8];
              end
            end
          end else begin
            // A read byte completes one cycle after issue, when captured.
            if (vld_pipe[1]) begin
              rdata_q[{idx1, 3'b000} +: 8] <= mem_din;
              cnt <= idx1 + 2'd1;
              if (idx1 == cur.len) state <= DONE;
            end
            vld_pipe[1] <= vld_pipe[0];
            idx1        <= idx0;
            if (vld_pipe[0]) begin
              if (idx0 == cur.len) begin
                vld_pipe[0] <= 1'b0;
              end else begin
                idx0    <= idx0 + 2'd1;
                mem_a_q <= mem_a_q + ADDR_WIDTH'(1);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The bus counts as used only in a real issue cycle: transfer active,
  // a byte on the bus, and the bus not lent out.
  logic issue;
  assign issue         = (state == XFER) & vld_pipe[0] & rdy_in;
  assign mem_a         = mem_a_q;
  assign mem_dout      = mem_dout_q;
  assign mem_wr        = issue & cur.wr;
  assign io_access_out = issue & (mem_a_q[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1] == 2'b11);
  assign rdata_out     = rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (NUM_CH=3). A behavioural RAM with one
// cycle of read latency sits on the byte bus. Inputs are driven 1 ns after
// each rising edge, and outputs are sampled on the falling edge.
module tb_mem_bus_arbiter;
  localparam int NC = 3;

  logic            clk_in = 1'b0;
  logic            rstn_in, rdy_in;
  logic [NC-1:0]   req_in, wr_in, done_out;
  logic [2*NC-1:0] len_in;
  logic [32*NC-1:0] addr_in, wdata_in;
  logic [31:0]     rdata_out, mem_a;
  logic [7:0]      mem_din, mem_dout;
  logic            mem_wr, io_access_out;

  int checks = 0, passes = 0, fails = 0;

  mem_bus_arbiter #(.NUM_CH(NC), .ADDR_WIDTH(32), .RAM_ADDR_WIDTH(17)) dut (
    .clk_in(clk_in), .rstn_in(rstn_in), .rdy_in(rdy_in),
    .req_in(req_in), .wr_in(wr_in), .len_in(len_in), .addr_in(addr_in),
    .wdata_in(wdata_in), .done_out(done_out), .rdata_out(rdata_out),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_access_out(io_access_out)
  );

  always #5 clk_in = ~clk_in;

  // RAM model: fixed initial contents plus a map of bytes written so far.
  logic [7:0] wmem [logic [17:0]];

  function automatic logic [7:0] init_byte(input logic [17:0] a);
    case (a)
      18'h00100: return 8'h11;
      18'h00101: return 8'h22;
      18'h00102: return 8'h33;
      18'h00103: return 8'h44;
      18'h00200: return 8'hA1;
      18'h00201: return 8'hB2;
      18'h00202: return 8'hC3;
      18'h00203: return 8'hD4;
      18'h30000: return 8'h5A;
      default:   return 8'hEE;
    endcase
  endfunction

  function automatic logic [7:0] ram_rd(input logic [17:0] a);
    if (wmem.exists(a)) return wmem[a];
    return init_byte(a);
  endfunction

  always @(posedge clk_in) begin
    mem_din <= ram_rd(mem_a[17:0]);
    if (mem_wr) wmem[mem_a[17:0]] = mem_dout;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_ch(input int c, input logic w, input logic [1:0] l,
                        input logic [31:0] a, input logic [31:0] d);
    wr_in[c]           = w;
    len_in[2*c +: 2]   = l;
    addr_in[32*c +: 32] = a;
    wdata_in[32*c +: 32] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [NC-1:0] drop;
  logic [NC-1:0] got [4];
  logic [31:0]   rdv [4];
  int            n;

  initial begin
    rstn_in = 1'b0; rdy_in = 1'b1; req_in = '0; wr_in = '0;
    len_in = '0; addr_in = '0; wdata_in = '0;
    nc(); nc();
    @(negedge clk_in);
    check("rst_done", done_out, 0);
    check("rst_rdata", rdata_out, 0);
    check("rst_mem_a", mem_a, 0);
    check("rst_dout", mem_dout, 0);
    check("rst_wr", mem_wr, 0);
    check("rst_io", io_access_out, 0);
    nc(); rstn_in = 1'b1;
    nc();

    // ---- single 4-byte read on ch0 ----
    set_ch(0, 1'b0, 2'd3, 32'h100, 32'h0);
    req_in = 3'b001;                                   // cycle t
    @(negedge clk_in); check("rd_t_done", done_out, 0);
    for (int i = 0; i < 4; i++) begin                  // t+1..t+4
      nc(); @(negedge clk_in);
      check("rd_addr", mem_a, 32'h100 + i);
      check("rd_wr", mem_wr, 0);
    end
    nc(); @(negedge clk_in); check("rd_t5_done", done_out, 0);
    nc(); @(negedge clk_in);                           // t+6
    check("rd_done", done_out, 3'b001);
    check("rd_data", rdata_out, 32'h44332211);
    nc(); req_in = 3'b000;
    @(negedge clk_in); check("rd_after_done", done_out, 0);

    // ---- 2-byte write on ch1 across the 0x1FFFF/0x20000 boundary ----
    set_ch(1, 1'b1, 2'd1, 32'h1FFFF, 32'hAABBCCDD);
    nc(); req_in = 3'b010;                             // t
    nc(); @(negedge clk_in);                           // t+1
    check("wr0_a", mem_a, 32'h1FFFF); check("wr0_wr", mem_wr, 1); check("wr0_d", mem_dout, 8'hDD);
    nc(); @(negedge clk_in);                           // t+2
    check("wr1_a", mem_a, 32'h20000); check("wr1_wr", mem_wr, 1); check("wr1_d", mem_dout, 8'hCC);
    nc(); @(negedge clk_in);                           // t+3
    check("wr_done", done_out, 3'b010); check("wr_done_wr", mem_wr, 0);
    nc(); req_in = 3'b000; @(negedge clk_in);
    check("wr_idle_wr", mem_wr, 0); check("wr_idle_a", mem_a, 32'h20000);
    check("wr_ram0", ram_rd(18'h1FFFF), 8'hDD);
    check("wr_ram1", ram_rd(18'h20000), 8'hCC);

    // ---- IO-region single-byte read on ch2 ----
    set_ch(2, 1'b0, 2'd0, 32'h30000, 32'h0);
    nc(); req_in = 3'b100;                             // t
    nc(); @(negedge clk_in);                           // t+1
    check("io_a", mem_a, 32'h30000); check("io_flag", io_access_out, 1); check("io_wr", mem_wr, 0);
    nc(); @(negedge clk_in);                           // t+2
    check("io_flag_off", io_access_out, 0); check("io_t2_done", done_out, 0);
    nc(); @(negedge clk_in);                           // t+3
    check("io_done", done_out, 3'b100); check("io_data", rdata_out, 32'h0000005A);
    nc(); req_in = 3'b000;

    // ---- round-robin with all three channels requesting ----
    set_ch(0, 1'b0, 2'd0, 32'h100, 32'h0);
    set_ch(1, 1'b0, 2'd0, 32'h101, 32'h0);
    set_ch(2, 1'b0, 2'd0, 32'h102, 32'h0);
    drop = '0; n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      nc(); req_in = 3'b111 & ~drop;
      @(negedge clk_in);
      drop = done_out;
      if (done_out != 0) begin
        got[n] = done_out; rdv[n] = rdata_out; n++;
      end
    end
    check("rr_count", n, 4);
    check("rr_g0", got[0], 3'b001); check("rr_d0", rdv[0], 32'h11);
    check("rr_g1", got[1], 3'b010); check("rr_d1", rdv[1], 32'h22);
    check("rr_g2", got[2], 3'b100); check("rr_d2", rdv[2], 32'h33);
    check("rr_g3", got[3], 3'b001); check("rr_d3", rdv[3], 32'h11);
    nc(); req_in = 3'b000;
    repeat (6) nc();

    // ---- 4-byte read with the bus paused during the byte-2 capture ----
    set_ch(0, 1'b0, 2'd3, 32'h200, 32'h0);
    nc(); req_in = 3'b001;                             // t
    for (int i = 0; i < 3; i++) begin                  // t+1..t+3
      nc(); @(negedge clk_in); check("pz_addr", mem_a, 32'h200 + i);
    end
    for (int i = 0; i < 3; i++) begin                  // t+4..t+6
      nc(); rdy_in = 1'b0; @(negedge clk_in);
      check("pz_wr", mem_wr, 0); check("pz_done", done_out, 0); check("pz_io", io_access_out, 0);
    end
    nc(); rdy_in = 1'b1; @(negedge clk_in);            // t+7
    check("pz_reissue", mem_a, 32'h202); check("pz_wr2", mem_wr, 0);
    nc(); @(negedge clk_in); check("pz_b3", mem_a, 32'h203);   // t+8
    nc(); @(negedge clk_in); check("pz_t9_done", done_out, 0);  // t+9
    nc(); rdy_in = 1'b0; @(negedge clk_in);            // t+10
    check("pz_deferred", done_out, 0);
    nc(); rdy_in = 1'b1; @(negedge clk_in);            // t+11
    check("pz_done_now", done_out, 3'b001);
    check("pz_data", rdata_out, 32'hD4C3B2A1);
    nc(); req_in = 3'b000;

    // ---- asynchronous reset in the middle of a write ----
    set_ch(1, 1'b1, 2'd3, 32'h400, 32'h01020304);
    nc(); req_in = 3'b010;                             // t
    nc(); @(negedge clk_in);                           // t+1
    check("rs_wr", mem_wr, 1); check("rs_a", mem_a, 32'h400); check("rs_d", mem_dout, 8'h04);
    nc(); rstn_in = 1'b0; #1;
    check("rs_now_a", mem_a, 0); check("rs_now_wr", mem_wr, 0);
    check("rs_now_d", mem_dout, 0); check("rs_now_done", done_out, 0);
    check("rs_now_io", io_access_out, 0); check("rs_now_rdata", rdata_out, 0);
    nc(); req_in = 3'b000; @(negedge clk_in); check("rs_hold_done", done_out, 0);
    nc(); rstn_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nc(); @(negedge clk_in); check("rs_no_done", done_out, 0);
    end
    check("rs_ram_b0", ram_rd(18'h00400), 8'h04);
    check("rs_ram_b1", ram_rd(18'h00401), 8'hEE);
    set_ch(0, 1'b0, 2'd0, 32'h100, 32'h0);
    set_ch(1, 1'b0, 2'd0, 32'h101, 32'h0);
    set_ch(2, 1'b0, 2'd0, 32'h102, 32'h0);
    nc(); req_in = 3'b111;                             // t'
    nc(); @(negedge clk_in); check("rs_prio_a", mem_a, 32'h100);
    nc(); @(negedge clk_in);
    nc(); @(negedge clk_in);                           // t'+3
    check("rs_prio_done", done_out, 3'b001); check("rs_prio_data", rdata_out, 32'h11);
    nc(); req_in = 3'b000;
    repeat (8) nc();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Parametrised successor to the single-master CPU/HCI memory mux: arbitrates NUM_CH requesters (e.g. ifetch, load/store, debug) onto the 8-bit byte-serial RAM/IO bus.
- Each request is a 1–4 byte little-endian read or write.
- Round-robin fairness, pipelined byte transfers over the 1-cycle-latency RAM, IO-region decode, and freeze/replay on bus-pause (rdy low).

Parameters:
- NUM_CH, 3, number of requester channels (2..8).
- ADDR_WIDTH, 32, requester and bus address width.
- RAM_ADDR_WIDTH, 17, RAM index width; IO region is addr[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]==2'b11.

Ports:
- clk_in  input  1  system clock.
- rstn_in  input  1  asynchronous active-low reset.
- rdy_in  input  1  bus available; low = bus lent to debug host, arbiter frozen.
- req_in  input  NUM_CH  per-channel request, held until done.
- wr_in  input  NUM_CH  per-channel 1=write, 0=read.
- len_in  input  2*NUM_CH  per-channel byte count minus 1 (0..3 → 1..4 bytes).
- addr_in  input  ADDR_WIDTH*NUM_CH  per-channel start byte address.
- wdata_in  input  32*NUM_CH  per-channel write data, byte i at [8i+7:8i].
- done_out  output  NUM_CH  one-cycle completion pulse to the granted channel.
- rdata_out  output  32  read data, valid while any done_out bit is high; unused upper bytes zero.
- mem_din  input  8  byte from RAM/IO, valid one cycle after its address.
- mem_dout  output  8  write byte.
- mem_a  output  ADDR_WIDTH  bus byte address.
- mem_wr  output  1  1=write.
- io_access_out  output  1  current bus cycle targets the IO region.

Behaviour:
- Reset values:
  - done_out=0, rdata_out=0, mem_a=0, mem_dout=0, mem_wr=0, io_access_out=0.
  - state=IDLE; RR pointer=channel 0 highest priority.
- States:
  - IDLE: if rdy_in and any eligible req, latch channel c, wr, len, addr, wdata → XFER.
  - XFER: issue bytes; → DONE after the last issue (write) or last capture (read).
  - DONE: pulse done_out[c], drive rdata_out → IDLE.
- Arbitration:
  - Round-robin starting at (last granted+1) mod NUM_CH.
  - A channel whose done_out is high this cycle is ineligible this cycle.
  - Requesters drop req the cycle after done.
- Timing, grant sampled at cycle t, L = len+1:
  - Byte i address is driven in cycle t+1+i, mem_a = addr+i, ADDR_WIDTH wrap-around allowed.
  - Write: mem_wr=1 and mem_dout=wdata byte i in the same cycle. done_out in cycle t+L+1.
  - Read: mem_wr=0; byte i captured from mem_din at end of cycle t+2+i into rdata byte i. done_out in cycle t+L+2.
- Idle bus: outside issue cycles mem_wr=0 and mem_a holds its last value; this is never a write.
- io_access_out = IO-region decode of the currently driven mem_a, qualified by issue cycle.
- IO-region bytes are issued exactly once each. No speculative or repeated issue except replay after pause (below).
- rdy_in low (any state):
  - mem_wr forced 0; state, counters and pointer held; done_out not asserted.
  - A read byte whose capture cycle coincides with rdy low is discarded.
  - On rdy return, issue resumes at the lowest uncaptured byte index. Completed writes are not repeated; an unissued write byte is issued when rdy returns.
  - done pulse deferred until the first cycle rdy_in is high.
- Simultaneous requests: exactly one grant, per the RR order.
- Changes to a non-granted channel's inputs have no effect. The granted channel's inputs are latched at grant, so later changes are ignored.
- Reset mid-transfer: immediate return to reset values; partial transfer abandoned; no done.

Test Plan:
- Single read: ch0 req, len=3, addr=0x100, RAM bytes 11,22,33,44 at 0x100.. (hex) → mem_a 0x100..0x103 in consecutive cycles; done_out=001 at t+6; rdata_out=0x44332211.
- Write: ch1 req, wr=1, len=1, addr=0x1FFFF, wdata=0xAABBCCDD → cycles t+1 and t+2 write DD@0x1FFFF then CC@0x20000; done at t+3; mem_wr low otherwise.
- Round-robin: ch0, ch1, ch2 all request continuously → grants in order 0,1,2,0; no channel granted twice while another waits.
- IO region: ch2 read, len=0, addr=0x30000 → single issue with io_access_out=1; rdata_out=0x000000XX with XX=mem_din; done at t+3.
- Pause: 4-byte read; rdy_in low during byte-2 capture for 3 cycles → byte 2 reissued after resume; correct word returned; mem_wr=0 throughout; done only when rdy_in=1.
- Async reset: rstn_in low mid-write → outputs zero immediately; no done; after release, ch0 has top priority.
